// File: rtl/bp_pkg.sv
// Shared sizing, FSM encoding and helpers for the bp_sched job scheduler.
package bp_pkg;
  localparam int NUM_REQ    = 2;
  localparam int ROW_W      = 16;
  localparam int GUY_W      = 3;
  localparam int MOVE_W     = 2;
  localparam int MAX_ROWS   = 64;
  localparam int WDOG_LIMIT = 1023;
  localparam int PTR_W      = 1;
  localparam int CNT_W      = 7;
  localparam int WDOG_W     = 10;

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_LOAD, S_RUN, S_DONE} state_t;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [PTR_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/bp_rr_arb.sv
// Combinational round-robin pick: first requester at or after rr_ptr wins.
module bp_rr_arb import bp_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick
);
  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // NUM_REQ is a power of two, so the index wraps by plain overflow.
  always_comb begin
    pick    = '0;
    w_found = 1'b0;
    w_idx   = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = rr_ptr + PTR_W'(i);
      if (!w_found && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        w_found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bp_sched.sv
// bp_sched: round-robin job scheduler feeding one shared move engine.
// Define BP_SCHED_WDOG_EN to add a RUN-state watchdog on engine silence.
module bp_sched import bp_pkg::*; (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  output logic [NUM_REQ-1:0]       gnt,
  input  logic [NUM_REQ-1:0]       s_valid,
  input  logic [NUM_REQ*GUY_W-1:0] s_guy,
  input  logic [NUM_REQ*ROW_W-1:0] s_row,
  output logic                     e_in_valid,
  output logic [GUY_W-1:0]         e_guy,
  output logic [ROW_W-1:0]         e_row,
  input  logic                     e_out_valid,
  input  logic [MOVE_W-1:0]        e_out,
  output logic [NUM_REQ-1:0]       r_valid,
  output logic [MOVE_W-1:0]        r_out,
  output logic                     busy,
  output logic                     err
);
  state_t             r_state, w_next;
  logic [NUM_REQ-1:0] w_pick, r_rvalid;
  logic [PTR_W-1:0]   w_pick_idx, r_ptr, r_owner;
  logic [CNT_W-1:0]   r_rows;
  logic               r_in_seen, r_out_seen, r_ovf, r_err, r_in_valid;
  logic [GUY_W-1:0]   r_guy;
  logic [ROW_W-1:0]   r_row;
  logic [MOVE_W-1:0]  r_rout;
  logic               w_sv;
  logic [GUY_W-1:0]   w_sg;
  logic [ROW_W-1:0]   w_sr;
  logic               w_accept, w_ovf_row, w_load_end, w_run_end;
  logic               w_wdog_hit, w_wdog_fire;

  bp_rr_arb u_arb (.req(req), .rr_ptr(r_ptr), .pick(w_pick));

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
  end

  assign w_sv = s_valid[r_owner];
  assign w_sg = s_guy[int'(r_owner)*GUY_W +: GUY_W];
  assign w_sr = s_row[int'(r_owner)*ROW_W +: ROW_W];

  // Rows past MAX_ROWS are swallowed; only the first one raises err.
  assign w_accept   = (r_state == S_LOAD) && w_sv && (r_rows <  CNT_W'(MAX_ROWS));
  assign w_ovf_row  = (r_state == S_LOAD) && w_sv && (r_rows == CNT_W'(MAX_ROWS));
  assign w_load_end = (r_state == S_LOAD) && r_in_seen && !w_sv;
  assign w_run_end  = (r_state == S_RUN) && r_out_seen && !e_out_valid;

`ifdef BP_SCHED_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;
  assign w_wdog_hit  = (r_state == S_RUN) && !e_out_valid && (r_wdog == WDOG_W'(WDOG_LIMIT - 1));
  assign w_wdog_fire = (r_state == S_RUN) && (r_wdog == WDOG_W'(WDOG_LIMIT));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_wdog <= '0;
    else if (r_state != S_RUN || e_out_valid) r_wdog <= '0;
    else if (!w_wdog_fire)                   r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_wdog_hit  = 1'b0;
  assign w_wdog_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_next = S_GRANT;
      S_GRANT: w_next = S_LOAD;
      S_LOAD:  if (w_load_end) w_next = S_RUN;
      S_RUN:   if (w_run_end || w_wdog_fire) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_owner    <= '0;
      r_rows     <= '0;
      r_in_seen  <= 1'b0;
      r_out_seen <= 1'b0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
      r_in_valid <= 1'b0;
      r_guy      <= '0;
      r_row      <= '0;
      r_rvalid   <= '0;
      r_rout     <= '0;
    end else begin
      r_err      <= (w_ovf_row && !r_ovf) || w_wdog_hit;
      r_in_valid <= w_accept;
      if (w_accept) begin
        r_guy <= w_sg;
        r_row <= w_sr;
      end
      r_rvalid <= (r_state == S_RUN && e_out_valid) ? idx2oh(r_owner) : '0;
      r_rout   <= (r_state == S_RUN && e_out_valid) ? e_out : '0;
      case (r_state)
        S_IDLE:  if (|req) r_owner <= w_pick_idx;
        S_GRANT: begin
          r_rows     <= '0;
          r_ovf      <= 1'b0;
          r_in_seen  <= 1'b0;
          r_out_seen <= 1'b0;
        end
        S_LOAD: begin
          if (w_accept)  r_rows    <= r_rows + 1'b1;
          if (w_ovf_row) r_ovf     <= 1'b1;
          if (w_sv)      r_in_seen <= 1'b1;
        end
        S_RUN:   if (e_out_valid) r_out_seen <= 1'b1;
        S_DONE:  r_ptr <= r_owner + 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt        = (r_state == S_GRANT) ? idx2oh(r_owner) : '0;
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;
  assign e_in_valid = r_in_valid;
  assign e_guy      = r_guy;
  assign e_row      = r_row;
  assign r_valid    = r_rvalid;
  assign r_out      = r_rout;
endmodule

// File: tb/tb_bp_sched.sv
// Randomized bench for bp_sched: transaction scoreboards for engine rows and
// results, round-robin owner model; watchdog checks follow BP_SCHED_WDOG_EN.
module tb_bp_sched;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, s_valid, r_valid, e_out, r_out;
  logic [5:0]  s_guy;
  logic [31:0] s_row;
  logic        e_in_valid, e_out_valid, busy, err;
  logic [2:0]  e_guy;
  logic [15:0] e_row;

  bp_sched dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .s_valid(s_valid), .s_guy(s_guy),
    .s_row(s_row), .e_in_valid(e_in_valid), .e_guy(e_guy), .e_row(e_row),
    .e_out_valid(e_out_valid), .e_out(e_out), .r_valid(r_valid), .r_out(r_out),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [2:0] guy; logic [15:0] row; } erow_t;
  typedef struct { int cyc; logic [1:0] own; logic [1:0] code; } res_t;
  erow_t eq[$];
  res_t  rq[$];
  int    cyc, total, bad, err_cnt, ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score everything the engine/result side shows.
  task automatic step();
    bit ex;
    @(negedge clk);
    cyc++;
    if (err) err_cnt++;
    ex = (eq.size() > 0) && (eq[0].cyc == cyc);
    chk("e_in_valid", e_in_valid, ex);
    if (ex) begin
      if (e_in_valid) begin
        chk("e_guy", e_guy, eq[0].guy);
        chk("e_row", e_row, eq[0].row);
      end
      void'(eq.pop_front());
    end
    ex = (rq.size() > 0) && (rq[0].cyc == cyc);
    if (ex) begin
      chk("r_valid", r_valid, 2'(1) << rq[0].own);
      chk("r_out", r_out, rq[0].code);
      void'(rq.pop_front());
    end else begin
      chk("r_valid_idle", r_valid, 2'b00);
      chk("r_out_zero", r_out, 2'b00);
    end
  endtask

  task automatic junk(input int own);
    s_valid      = 2'($urandom);
    s_guy        = 6'($urandom);
    s_row        = $urandom;
    s_valid[own] = 1'b0;
  endtask

  task automatic arrive();
    int b = $urandom_range(1, 0);
    if ($urandom_range(5, 0) == 0)       req[b] = 1'b1;
    else if ($urandom_range(11, 0) == 0) req[b] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; s_valid = '0; s_guy = '0; s_row = '0;
    e_out_valid = 1'b0; e_out = '0;
    eq.delete(); rq.delete(); ptr = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {gnt, e_in_valid, e_guy, e_row, r_valid, r_out, busy, err}, '0);
    rst = 1'b0;
  endtask

  // nmov==0 leaves the engine silent (watchdog case); abort resets mid-RUN.
  task automatic run_job(input int nrows, input int nmov, input bit both, input bit abort,
                         output int got_own);
    int own, gw, first_err, idle_at;
    logic [2:0]  g;
    logic [15:0] r;
    logic [1:0]  c;
    got_own = -1;
    if (req == 2'b00) req[$urandom_range(1, 0)] = 1'b1;
    gw = 0;
    do begin step(); junk(0); gw++; end while (gnt == 2'b00 && gw < 20);
    chk("gnt_seen", gnt != 2'b00, 1'b1);
    if (gnt == 2'b00) return;
    own = req[ptr] ? ptr : 1 - ptr;
    chk("gnt_owner", gnt, 2'(1) << own);
    got_own = gnt[1] ? 1 : 0;
    ptr = 1 - own; req[own] = 1'b0; err_cnt = 0; e_out_valid = 1'b0;
    step(); junk(own);
    chk("gnt_pulse", gnt, 2'b00);
    chk("busy_job", busy, 1'b1);
    if (both) req = 2'b11;
    repeat ($urandom_range(2, 0)) begin step(); junk(own); end
    for (int k = 0; k < nrows; k++) begin
      g = 3'($urandom); r = 16'($urandom);
      s_valid[own] = 1'b1; s_guy[own*3 +: 3] = g; s_row[own*16 +: 16] = r;
      if (k < MAX_ROWS) eq.push_back('{cyc + 1, g, r});
      if (!both) arrive();
      step(); junk(own);
    end
    step(); junk(own);
    if (nmov == 0) begin
      first_err = -1; idle_at = -1;
      for (int n = 1; n <= 1100; n++) begin
        step(); junk(own);
        if (err && first_err < 0) first_err = n;
        if (!busy && idle_at < 0) idle_at = n;
      end
`ifdef BP_SCHED_WDOG_EN
      chk("wdog_err_at", first_err, 1023);
      chk("wdog_idle_at", idle_at, 1025);
`else
      chk("wdog_off_err", first_err, -1);
      chk("wdog_off_busy", busy, 1'b1);
`endif
      return;
    end
    repeat ($urandom_range(2, 0)) begin e_out = 2'($urandom); step(); junk(own); end
    for (int k = 0; k < nmov; k++) begin
      c = 2'($urandom); e_out_valid = 1'b1; e_out = c;
      rq.push_back('{cyc + 1, 2'(own), c});
      if (!both) arrive();
      step(); junk(own);
    end
    if (abort) begin
      rst = 1'b1;
      #1;
      chk("rst_outs", {gnt, e_in_valid, e_guy, e_row, r_valid, r_out, busy, err}, '0);
      eq.delete(); rq.delete(); ptr = 0; req = 2'b00;
      for (int k = 0; k < 6; k++) begin
        e_out_valid = ~e_out_valid; e_out = 2'($urandom);
        if (k == 2) rst = 1'b0;
        step();
        chk("rst_busy", busy, 1'b0);
      end
      e_out_valid = 1'b0;
      return;
    end
    e_out_valid = 1'b0; e_out = 2'($urandom);
    step(); junk(own);
    chk("busy_done", busy, 1'b1);
    step(); junk(own);
    chk("busy_idle", busy, 1'b0);
    chk("err_pulses", err_cnt, nrows > MAX_ROWS);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int o;
    cyc = 0; total = 0; bad = 0; err_cnt = 0; ptr = 0;
    do_reset();

    req = 2'b01;
    run_job(5, 7, 0, 0, o);  chk("single_owner", o, 0);

    do_reset();
    req = 2'b11;
    run_job(4, 3, 1, 0, o);  chk("order_a", o, 0);
    run_job(6, 2, 1, 0, o);  chk("order_b", o, 1);
    run_job(3, 4, 1, 0, o);  chk("order_c", o, 0);
    run_job(70, 5, 1, 0, o); chk("ovf_owner", o, 1);

    for (int j = 0; j < 16; j++)
      run_job(($urandom_range(7, 0) == 0) ? $urandom_range(70, 60) : $urandom_range(12, 1),
              $urandom_range(8, 1), 0, 0, o);

    run_job(3, 4, 0, 1, o);
    req = 2'b11;
    run_job(2, 2, 0, 0, o);  chk("post_rst_owner", o, 0);

    req = 2'b00;
    run_job(2, 0, 0, 0, o);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bp_sched.md
BP_SCHED -- requirements
Module: bp_sched

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-002 Requester ports SHALL be: req input 2, per-requester job request, level, held until gnt; gnt output 2, one-hot grant, 1-cycle pulse.
REQ-003 Requester data SHALL be: s_valid input 2, per-requester row valid; s_guy input 6, 3 bits per requester, start lane on first row; s_row input 32, 16 bits per requester, 8 lanes x 2 bits.
REQ-004 Engine-side ports SHALL be: e_in_valid output 1; e_guy output 3; e_row output 16; e_out_valid input 1; e_out input 2, engine move code.
REQ-005 Result ports SHALL be: r_valid output 2, one-hot result valid to owner; r_out output 2, forwarded move code; busy output 1, high outside IDLE; err output 1, 1-cycle pulse on overflow or timeout.

Function
REQ-006 FSM states SHALL be IDLE, GRANT, LOAD, RUN, DONE; only one job owns the engine at a time.
REQ-007 In IDLE with any req bit high, the block SHALL pick the owner round-robin from pointer rr_ptr, starting at rr_ptr, and go to GRANT.
REQ-008 In GRANT, gnt[owner] SHALL pulse for exactly one cycle; the next state SHALL be LOAD.
REQ-009 In LOAD, the owner's s_valid, s_guy and s_row SHALL be registered to e_in_valid, e_guy and e_row with exactly 1-cycle latency; non-owner inputs SHALL be ignored.
REQ-010 LOAD SHALL end on the first cycle that s_valid[owner] is low after having been high; the next state SHALL be RUN, and e_in_valid SHALL be low in the cycle after.
REQ-011 A 7-bit row counter SHALL count rows; rows beyond 64 SHALL be dropped (e_in_valid held low), and err SHALL pulse once per job.
REQ-012 In RUN, each cycle with e_out_valid=1 SHALL produce r_valid[owner]=1 and r_out=e_out one cycle later; r_out SHALL be 0 when r_valid is 0.
REQ-013 RUN SHALL go to DONE on the first cycle e_out_valid is low after having been high.
REQ-014 DONE SHALL last one cycle, set rr_ptr to owner+1 mod 2, and return to IDLE, guaranteeing at least 2 idle cycles on e_in_valid between jobs.
REQ-015 A req that drops before gnt SHALL be ignored in the next arbitration; a req asserted during a job SHALL wait, not be lost.
REQ-016 When both req bits are high in IDLE, requester rr_ptr SHALL win.

Reset
REQ-017 On rst, the block SHALL set state=IDLE, rr_ptr=0, counters=0, and all outputs (gnt, e_in_valid, e_guy, e_row, r_valid, r_out, busy, err) to 0 immediately.
REQ-018 rst asserted mid-job SHALL abort the job with no further r_valid; the engine sees e_in_valid=0.

Configuration
REQ-019 With macro BP_SCHED_WDOG_EN defined, a 10-bit watchdog SHALL count RUN cycles without e_out_valid. At 1023 it SHALL pulse err and go to DONE. Without the macro, there SHALL be no watchdog, and RUN SHALL wait indefinitely.

Structure
REQ-020 Package bp_pkg SHALL hold the FSM state typedef, NUM_REQ=2, ROW_W=16, MAX_ROWS=64, and WDOG_LIMIT=1023.
REQ-021 Round-robin selection SHALL live in sub-module bp_rr_arb: inputs req and rr_ptr, output one-hot pick, combinational.

Verification
REQ-022 req=01, 5 rows, then engine returns 7 moves -> gnt=01 for 1 cycle; 5 e_in_valid cycles lagging s_valid by 1; r_valid=01 for 7 cycles; busy low after DONE.
REQ-023 req=11 from reset -> requester 0 served first, then requester 1; if both keep requesting, order is 0,1,0.
REQ-024 Requester 1 streams 70 rows -> exactly 64 e_in_valid cycles; err pulses once; results still return to requester 1.
REQ-025 rst asserted during RUN with e_out_valid toggling -> all outputs 0 next edge; no r_valid afterwards; state IDLE.
REQ-026 With BP_SCHED_WDOG_EN defined, engine never asserts e_out_valid -> err after 1023 RUN cycles; busy drops 2 cycles later; without the macro, busy stays high.
